// File: rtl/ofdm_rx_pkg.sv
// Shared types and LTE defaults for the OFDM receive chain.
// Used by the CP remover and the FFT framer.
package ofdm_rx_pkg;

   typedef enum logic {
      STATE_CP,
      STATE_BODY
   } cp_state_t;

   localparam int TUSER_SOS   = 0;
   localparam int TUSER_TRUNC = 1;

   localparam int FFT_SIZE_20MHZ     = 2048;
   localparam int CP_LEN_FIRST_NORM  = 160;
   localparam int CP_LEN_NORM        = 144;
   localparam int SYMS_PER_SLOT_NORM = 7;

   function automatic int max3(int a, int b, int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/cp_remover_if.sv
// AXI4-Stream bundle with master/slave views.
// The slave view carries no tuser.
interface cp_remover_if #(
   parameter int DW = 48,
   parameter int UW = 2
);
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tready;
   logic          tlast;
   logic [UW-1:0] tuser;

   modport master (
      output tdata, tvalid, tlast, tuser,
      input  tready
   );

   modport slave (
      input  tdata, tvalid, tlast,
      output tready
   );
endinterface

// File: rtl/axis_reg_slice.sv
// Single registered AXI4-Stream output stage.
// Full throughput: ready while empty or draining.
module axis_reg_slice #(
   parameter int DW = 48,
   parameter int UW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   input  logic [UW-1:0] in_user,
   output logic          in_ready,
   cp_remover_if.master  m
);

   logic          valid_q, valid_d;
   logic          last_q, last_d;
   logic [DW-1:0] data_q, data_d;
   logic [UW-1:0] user_q, user_d;

   assign in_ready = !valid_q || m.tready;

   always_comb begin
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      user_d  = user_q;
      if (in_valid && in_ready) begin
         valid_d = 1'b1;
         last_d  = in_last;
         data_d  = in_data;
         user_d  = in_user;
      end else if (m.tready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
         user_q  <= '0;
      end else begin
         valid_q <= valid_d;
         last_q  <= last_d;
         data_q  <= data_d;
         user_q  <= user_d;
      end
   end

   assign m.tvalid = valid_q;
   assign m.tlast  = last_q;
   assign m.tdata  = data_q;
   assign m.tuser  = user_q;

endmodule

// File: rtl/cp_remover.sv
// Cyclic-prefix removal: drops CP beats, forwards FFT_SIZE
// body beats per symbol with tlast/tuser framing.
module cp_remover
   import ofdm_rx_pkg::*;
#(
   parameter int WIDTH           = 12,
   parameter int NUM_CHANNELS    = 2,
   parameter int AXIS_DATA_WIDTH = NUM_CHANNELS*2*WIDTH,
   parameter int FFT_SIZE        = FFT_SIZE_20MHZ,
   parameter int CP_LEN_FIRST    = CP_LEN_FIRST_NORM,
   parameter int CP_LEN          = CP_LEN_NORM,
   parameter int SYMS_PER_SLOT   = SYMS_PER_SLOT_NORM
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enable,
   cp_remover_if.slave  s_axis,
   cp_remover_if.master m_axis,
   output logic [15:0]  slot_count
);

   localparam int CNT_MAX = max3(FFT_SIZE, CP_LEN_FIRST, CP_LEN);
   localparam int CW = $clog2(CNT_MAX);
   localparam int SW = (SYMS_PER_SLOT > 1) ? $clog2(SYMS_PER_SLOT) : 1;

   if (FFT_SIZE < 2) begin : g_bad_fft
      $error("FFT_SIZE must be >= 2");
   end
   if (CP_LEN < 1 || CP_LEN_FIRST < 1) begin : g_bad_cp
      $error("CP lengths must be >= 1");
   end
   if (SYMS_PER_SLOT < 1) begin : g_bad_syms
      $error("SYMS_PER_SLOT must be >= 1");
   end

   cp_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] sym_q, sym_d;
   logic [15:0]   slot_q, slot_d;

   logic          slice_rdy;
   logic          rdy;
   logic          accept;
   logic          body_valid;
   logic          body_last;
   logic [1:0]    body_user;
   logic [CW-1:0] cp_end;
   logic          body_end;
   logic          sym_wrap;

   assign cp_end = (sym_q == '0) ? CW'(CP_LEN_FIRST - 1)
                                 : CW'(CP_LEN - 1);
   assign body_end = (cnt_q == CW'(FFT_SIZE - 1));
   assign sym_wrap = (sym_q == SW'(SYMS_PER_SLOT - 1));

   assign rdy = !enable || (state_q == STATE_CP) || slice_rdy;
   assign accept = s_axis.tvalid && rdy;
   assign s_axis.tready = rdy;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sym_d      = sym_q;
      slot_d     = slot_q;
      body_valid = 1'b0;
      body_last  = 1'b0;
      body_user  = 2'b00;
      if (!enable) begin
         state_d = STATE_CP;
         cnt_d   = '0;
         sym_d   = '0;
      end else if (accept) begin
         unique case (state_q)
            STATE_CP: begin
               if (cnt_q == cp_end) begin
                  cnt_d   = '0;
                  state_d = STATE_BODY;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            STATE_BODY: begin
               body_valid = 1'b1;
               body_last  = body_end || s_axis.tlast;
               body_user[TUSER_SOS] = (cnt_q == '0) && (sym_q == '0);
               body_user[TUSER_TRUNC] = s_axis.tlast && !body_end;
               if (body_end) begin
                  cnt_d   = '0;
                  state_d = STATE_CP;
                  sym_d   = sym_wrap ? '0 : sym_q + SW'(1);
                  if (sym_wrap) slot_d = slot_q + 16'd1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: state_d = STATE_CP;
         endcase
         // tlast resyncs to slot start after any counting above
         if (s_axis.tlast) begin
            state_d = STATE_CP;
            cnt_d   = '0;
            sym_d   = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= STATE_CP;
         cnt_q   <= '0;
         sym_q   <= '0;
         slot_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sym_q   <= sym_d;
         slot_q  <= slot_d;
      end
   end

   assign slot_count = slot_q;

   axis_reg_slice #(
      .DW (AXIS_DATA_WIDTH),
      .UW (2)
   ) u_out (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (body_valid),
      .in_data  (s_axis.tdata),
      .in_last  (body_last),
      .in_user  (body_user),
      .in_ready (slice_rdy),
      .m        (m_axis)
   );

endmodule

// File: tb/tb_cp_remover.sv
// Directed scoreboard bench for cp_remover with a small
// frame (FFT 8, CP 3/2, 3 symbols per slot).
module tb_cp_remover;

   localparam int DW = 48;

   typedef struct packed {
      logic [1:0]    user;
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b1;
   logic [15:0] slot_count;

   cp_remover_if #(.DW(DW)) s_if ();
   cp_remover_if #(.DW(DW)) m_if ();

   cp_remover #(
      .WIDTH         (12),
      .NUM_CHANNELS  (2),
      .FFT_SIZE      (8),
      .CP_LEN_FIRST  (3),
      .CP_LEN        (2),
      .SYMS_PER_SLOT (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .s_axis     (s_if),
      .m_axis     (m_if),
      .slot_count (slot_count)
   );

   always #5 clk = ~clk;

   beat_t sb[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    cyc = 0;
   bit    toggle = 1'b0;
   bit    pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   function automatic logic [DW-1:0] word(int v);
      return {16'(v), 16'(~v), 16'(v * 3 + 7)};
   endfunction

   function automatic beat_t mk(int v, bit last, bit [1:0] user);
      beat_t b;
      b.user = user;
      b.last = last;
      b.data = word(v);
      return b;
   endfunction

   function automatic bit is_body(int v);
      return (v >= 3 && v <= 10) || (v >= 13 && v <= 20) ||
             (v >= 23 && v <= 30);
   endfunction

   task automatic chk(string tag, logic [63:0] got,
                      logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && m_if.tvalid && m_if.tready) begin
         if (sb.size() == 0) begin
            chk("extra_beat", 64'(sb.size()), 64'd1);
         end else begin
            beat_t e;
            beat_t g;
            e = sb.pop_front();
            g.user = m_if.tuser;
            g.last = m_if.tlast;
            g.data = m_if.tdata;
            chk("out_beat", 64'(g), 64'(e));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (toggle) m_if.tready = pat[cyc % 4];
   endtask

   task automatic send(int v, bit last, bit body, bit stall_chk);
      bit done;
      done = 1'b0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = word(v);
      s_if.tlast  = last;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (stall_chk && m_if.tvalid && !m_if.tready)
            chk("stall_rdy", 64'(s_if.tready), body ? 64'd0 : 64'd1);
         done = s_if.tready;
         tick();
      end
      if (!done) chk("send_timeout", 64'(done), 64'd1);
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   task automatic push_sym(int base, bit first);
      for (int j = 0; j < 8; j++)
         sb.push_back(mk(base + j, j == 7, {1'b0, first && j == 0}));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tlast = 1'b0;
      enable = 1'b1;
      toggle = 1'b0;
      m_if.tready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic drain();
      repeat (6) tick();
      chk("sb_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      s_if.tdata = '0;
      s_if.tuser = '0;
      s_if.tvalid = 1'b0;
      s_if.tlast = 1'b0;
      m_if.tready = 1'b1;
      do_reset();

      chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
      chk("rst_tlast", 64'(m_if.tlast), 64'd0);
      chk("rst_tuser", 64'(m_if.tuser), 64'd0);
      chk("rst_tdata", 64'(m_if.tdata), 64'd0);
      chk("rst_slot", 64'(slot_count), 64'd0);
      chk("rst_sready", 64'(s_if.tready), 64'd1);

      push_sym(3, 1'b1);
      push_sym(13, 1'b0);
      push_sym(23, 1'b0);
      for (int v = 0; v < 32; v++) send(v, 1'b0, is_body(v), 1'b0);
      drain();
      chk("slot_after_slot", 64'(slot_count), 64'd1);

      m_if.tready = 1'b0;
      send(32, 1'b0, 1'b0, 1'b0);
      send(33, 1'b0, 1'b0, 1'b0);
      send(34, 1'b0, 1'b1, 1'b0);
      chk("pend_valid", 64'(m_if.tvalid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_tvalid", 64'(m_if.tvalid), 64'd0);
      chk("arst_slot", 64'(slot_count), 64'd0);
      chk("arst_tlast", 64'(m_if.tlast), 64'd0);
      tick();
      rst_n = 1'b1;
      m_if.tready = 1'b1;
      tick();
      for (int j = 0; j < 8; j++)
         sb.push_back(mk(3 + j, j == 7, {1'b0, j == 0}));
      for (int v = 0; v <= 10; v++) send(v, 1'b0, 1'b0, 1'b0);
      drain();

      do_reset();
      toggle = 1'b1;
      push_sym(3, 1'b1);
      push_sym(13, 1'b0);
      push_sym(23, 1'b0);
      for (int v = 0; v < 32; v++) send(v, 1'b0, is_body(v), 1'b1);
      drain();
      chk("toggle_slot", 64'(slot_count), 64'd1);
      toggle = 1'b0;

      do_reset();
      sb.push_back(mk(3, 1'b0, 2'b01));
      sb.push_back(mk(4, 1'b0, 2'b00));
      sb.push_back(mk(5, 1'b0, 2'b00));
      sb.push_back(mk(6, 1'b1, 2'b10));
      push_sym(10, 1'b1);
      for (int v = 0; v < 18; v++) send(v, v == 6, 1'b0, 1'b0);
      drain();
      chk("resync_slot", 64'(slot_count), 64'd0);

      do_reset();
      enable = 1'b0;
      for (int v = 0; v < 5; v++) send(v, 1'b0, 1'b0, 1'b0);
      enable = 1'b1;
      push_sym(8, 1'b1);
      for (int v = 5; v < 16; v++) send(v, 1'b0, 1'b0, 1'b0);
      drain();
      chk("enable_slot", 64'(slot_count), 64'd0);

      do_reset();
      m_if.tready = 1'b0;
      sb.push_back(mk(3, 1'b0, 2'b01));
      for (int v = 0; v < 4; v++) send(v, 1'b0, 1'b0, 1'b0);
      tick();
      enable = 1'b0;
      repeat (3) tick();
      chk("hold_valid", 64'(m_if.tvalid), 64'd1);
      chk("hold_data", 64'(m_if.tdata), 64'(word(3)));
      chk("hold_user", 64'(m_if.tuser), 64'd1);
      send(4, 1'b0, 1'b0, 1'b0);
      send(5, 1'b0, 1'b0, 1'b0);
      chk("dis_sready", 64'(s_if.tready), 64'd1);
      m_if.tready = 1'b1;
      tick();
      tick();
      chk("flush_valid", 64'(m_if.tvalid), 64'd0);
      enable = 1'b1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cp_remover.md
Name: cp_remover

Overview:
- Dual-channel cyclic-prefix removal stage placed directly downstream of the NCO CFO compensator.
- Consumes CFO-corrected I/Q pairs on AXI4-Stream.
- Discards the CP samples of each OFDM symbol and forwards exactly FFT_SIZE body samples per symbol to the FFT stage.
- Marks each symbol end with tlast and tags slot start and truncation in tuser.

Parameters:
- WIDTH, 12, bits per I or Q component.
- NUM_CHANNELS, 2, number of antenna channels packed per beat.
- AXIS_DATA_WIDTH, NUM_CHANNELS*2*WIDTH, stream data width; the data word is passed unchanged.
- FFT_SIZE, 2048, body samples per symbol.
- CP_LEN_FIRST, 160, CP length of symbol 0 of each slot.
- CP_LEN, 144, CP length of symbols 1..SYMS_PER_SLOT-1.
- SYMS_PER_SLOT, 7, symbols per slot.

Ports:
- clk  in  1  fabric clock.
- rst_n  in  1  asynchronous active-low reset (asynchronous assert, synchronous deassert externally).
- enable  in  1  1 = remove CP and forward bodies; 0 = drop all input and hold the slot start.
- s_axis_tdata  in  AXIS_DATA_WIDTH  corrected I/Q from the CFO compensator.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of burst; the next accepted beat is the slot start (resync).
- m_axis_tdata  out  AXIS_DATA_WIDTH  body sample to the FFT.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last beat of a symbol body.
- m_axis_tuser  out  2  bit0 = first body beat of symbol 0; bit1 = symbol truncated by resync.
- slot_count  out  16  completed slots, wraps at 0xFFFF to 0.

Behaviour:
- Reset values:
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tuser = 0, m_axis_tdata = 0, slot_count = 0.
  - state = STATE_CP, sample_cnt = 0, sym_idx = 0.
- State STATE_CP:
  - s_axis_tready = 1 and the beat is discarded.
  - sample_cnt increments per accepted beat.
  - At cp_target-1 (CP_LEN_FIRST if sym_idx == 0, else CP_LEN): sample_cnt := 0 and state := STATE_BODY.
- State STATE_BODY:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready (single registered output stage, latency 1 cycle, full throughput).
  - Each accepted beat loads m_axis_tdata and asserts m_axis_tvalid.
  - tuser[0] = (sample_cnt == 0 && sym_idx == 0).
  - At sample_cnt == FFT_SIZE-1: m_axis_tlast = 1, sample_cnt := 0, state := STATE_CP.
    - sym_idx increments, wrapping to 0 after SYMS_PER_SLOT-1.
    - On that wrap, slot_count increments.
- m_axis_tvalid clears on a handshake when no new beat is accepted the same cycle. Output regs hold while tvalid && !tready.
- Resync on accepted s_axis_tlast:
  - After this beat: state := STATE_CP, sample_cnt := 0, sym_idx := 0. slot_count does not increment.
  - If the tlast beat is a body beat not at FFT_SIZE-1: forward it with m_axis_tlast = 1 and tuser[1] = 1.
  - If the tlast beat is at FFT_SIZE-1: normal tlast, tuser[1] = 0.
  - If the tlast beat is a CP beat: dropped, no output.
- enable = 0:
  - s_axis_tready = 1, input dropped, counters and state forced to the slot start.
  - A pending output beat is kept until handshaken; its data and tvalid are never cleared by enable.
- enable 1→0 mid-body:
  - The already-forwarded partial symbol is not terminated (no extra tlast).
  - The FFT stage must flush on enable.
- Simultaneous: the tlast resync and the final body beat at sym_idx == SYMS_PER_SLOT-1 → slot_count increments once, sym_idx := 0.
- Reset mid-operation: all state and outputs return to reset values immediately; no partial output is emitted afterwards.
- Width rules:
  - sample_cnt is $clog2(max(FFT_SIZE, CP_LEN_FIRST, CP_LEN)) bits.
  - sym_idx is $clog2(SYMS_PER_SLOT) bits, minimum 1.
- Elaboration-time assertions: FFT_SIZE ≥ 2, CP_LEN ≥ 1, CP_LEN_FIRST ≥ 1, SYMS_PER_SLOT ≥ 1.

Decomposition:
- Shared package ofdm_rx_pkg:
  - cp_state_t enum {STATE_CP, STATE_BODY}.
  - TUSER_SOS = 0, TUSER_TRUNC = 1 bit indices.
  - LTE defaults: FFT_SIZE_20MHZ = 2048, CP_LEN_FIRST_NORM = 160, CP_LEN_NORM = 144, SYMS_PER_SLOT_NORM = 7.
- One sub-module, axis_reg_slice: the registered output stage (data/last/user, ready = !valid || m_ready). It is reusable by the FFT framer.

Test Plan:
- Bench parameters: FFT_SIZE = 8, CP_LEN_FIRST = 3, CP_LEN = 2, SYMS_PER_SLOT = 3, m_axis_tready = 1.
  - Stream input counting 0..31 → outputs are input values 3..10 (tlast on 10, tuser[0] on 3), then 13..20, then 23..30.
  - Input beat 31 starts the next slot's CP. slot_count = 1 after the output of beat 30.
- Same stream with m_axis_tready toggling 1,0,0,1 → identical output sequence, no loss or duplication.
  - While m_axis_tvalid && !m_axis_tready: s_axis_tready = 0 in body, 1 in CP.
- s_axis_tlast on input beat 6 (4th body beat of symbol 0) → output 3..6 with tlast and tuser = 2'b10 on 6.
  - Beats 7..9 are dropped as the new CP. Next body starts at 10 with tuser[0] = 1. slot_count unchanged.
- enable = 0 for input beats 0..4, then 1 → beats 0..4 dropped. Beat 5 is treated as CP start, so the first output is 8.
- Output stalled with a pending beat, then enable dropped → the pending beat is still delivered intact once m_axis_tready = 1.
- rst_n asserted mid-body with m_axis_tvalid = 1 → m_axis_tvalid = 0 and slot_count = 0 immediately.
  - After release, input 0..10 → first output is 3.
